// File: rtl/cache_mem_rd_arbiter.sv
// rtl/cache_mem_rd_arbiter.sv - icache/dcache burst read arbiter onto a single memory read port (option: CACHE_ARB_RR_EN)
module cache_mem_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_raddr_i,
  input  logic              i_raddr_valid_i,
  input  logic [7:0]        i_rmask_i,
  input  logic [3:0]        i_rsize_i,
  input  logic [7:0]        i_rlen_i,
  output logic              i_rdata_ready_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic [ADDR_W-1:0] d_raddr_i,
  input  logic              d_raddr_valid_i,
  input  logic [7:0]        d_rmask_i,
  input  logic [3:0]        d_rsize_i,
  input  logic [7:0]        d_rlen_i,
  output logic              d_rdata_ready_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic [ADDR_W-1:0] ram_raddr_o,
  output logic              ram_raddr_valid_o,
  output logic [7:0]        ram_rmask_o,
  output logic [3:0]        ram_rsize_o,
  output logic [7:0]        ram_rlen_o,
  input  logic              ram_rdata_ready_i,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } state_t;

  localparam logic LG_I = 1'b0;
  localparam logic LG_D = 1'b1;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_beat_cnt;
  logic [7:0] w_beat_cnt_nxt;
  logic [7:0] r_rlen;
  logic [7:0] w_rlen_nxt;
  logic       r_last_grant;
  logic       w_last_grant_nxt;
  logic       w_prio_d;
  logic       w_pick_d;
  logic       w_x_valid;
  logic       w_hs;

  // Tie-break when both caches request in the same IDLE cycle
`ifdef CACHE_ARB_RR_EN
  assign w_prio_d = (r_last_grant == LG_I);
`else
  assign w_prio_d = 1'b1;
`endif

  assign w_pick_d  = d_raddr_valid_i & (~i_raddr_valid_i | w_prio_d);
  assign w_x_valid = ((r_state == ST_GNT_I) & i_raddr_valid_i) |
                     ((r_state == ST_GNT_D) & d_raddr_valid_i);
  assign w_hs      = w_x_valid & ram_rdata_ready_i;

  // Read data is broadcast; each cache qualifies it with its own ready
  assign i_rdata_o = ram_rdata_i;
  assign d_rdata_o = ram_rdata_i;

  // Route the granted master onto the memory port and return its handshake
  always_comb begin
    ram_raddr_o       = '0;
    ram_raddr_valid_o = 1'b0;
    ram_rmask_o       = '0;
    ram_rsize_o       = '0;
    ram_rlen_o        = '0;
    i_rdata_ready_o   = 1'b0;
    d_rdata_ready_o   = 1'b0;
    case (r_state)
      ST_GNT_I: begin
        ram_raddr_o       = i_raddr_i;
        ram_raddr_valid_o = i_raddr_valid_i;
        ram_rmask_o       = i_rmask_i;
        ram_rsize_o       = i_rsize_i;
        ram_rlen_o        = i_rlen_i;
        i_rdata_ready_o   = w_hs;
      end
      ST_GNT_D: begin
        ram_raddr_o       = d_raddr_i;
        ram_raddr_valid_o = d_raddr_valid_i;
        ram_rmask_o       = d_rmask_i;
        ram_rsize_o       = d_rsize_i;
        ram_rlen_o        = d_rlen_i;
        d_rdata_ready_o   = w_hs;
      end
      default: ;
    endcase
  end

  // Arbitration, beat counting, last-beat and abort detection
  always_comb begin
    w_state_nxt      = r_state;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_rlen_nxt       = r_rlen;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      ST_IDLE: begin
        if (i_raddr_valid_i | d_raddr_valid_i) begin
          w_beat_cnt_nxt = '0;
          if (w_pick_d) begin
            w_state_nxt = ST_GNT_D;
            w_rlen_nxt  = d_rlen_i;
          end else begin
            w_state_nxt = ST_GNT_I;
            w_rlen_nxt  = i_rlen_i;
          end
        end
      end
      ST_GNT_I, ST_GNT_D: begin
        if (!w_x_valid) begin
          // Master withdrew mid-burst: release the port, keep last_grant
          w_state_nxt    = ST_IDLE;
          w_beat_cnt_nxt = '0;
        end else if (w_hs) begin
          if (r_beat_cnt == r_rlen) begin
            w_state_nxt      = ST_IDLE;
            w_beat_cnt_nxt   = '0;
            w_last_grant_nxt = (r_state == ST_GNT_D) ? LG_D : LG_I;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_beat_cnt_nxt = '0;
      end
    endcase
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_beat_cnt   <= '0;
      r_rlen       <= '0;
      r_last_grant <= LG_D;
    end else begin
      r_state      <= w_state_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_rlen       <= w_rlen_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

endmodule
